// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the architectural fetch PC and drives the req/ack
// instruction-memory handshake.
// - Arbitrates the next PC among an EX branch, an ID jump and sequential PC+4.
// - Honours hazard stalls and raises registered pipeline flushes on redirect.
// - Optional build macro PC_ALIGN_CHECK_EN: misaligned redirect targets are
//   replaced by TRAP_PC and flagged on align_err.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC    = 32'h0000_0180,
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        id_branchPermit,
  input  logic [31:0] id_branchDst,
  input  logic        ex_branchPermit,
  input  logic [31:0] ex_branchDst,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic        if_valid,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        imem_err,
  output logic        align_err
);

  localparam int unsigned WCW = $clog2(WAIT_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pend_dst_q, pend_dst_d;
  logic             pend_q, pend_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             if_valid_q, if_valid_d;
  logic             flush_ifid_q, flush_ifid_d;
  logic             flush_idex_q, flush_idex_d;
  logic             imem_err_q, imem_err_d;
  logic             align_err_q, align_err_d;

  logic             redir_s;
  logic [31:0]      raw_dst_s;
  logic [31:0]      tgt_s;
  logic             misalign_s;
  logic [31:0]      pc_inc_s;

  assign pc_inc_s = pc_q + 32'd4;

  // Pick the redirect source: EX is older than ID, so it wins
  always_comb begin
    redir_s = ex_branchPermit | id_branchPermit;
    if (ex_branchPermit) begin
      raw_dst_s = ex_branchDst;
    end else begin
      raw_dst_s = id_branchDst;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  assign misalign_s = redir_s && (raw_dst_s[1:0] != 2'b00);
  assign tgt_s      = misalign_s ? TRAP_PC : raw_dst_s;
`else
  logic unused_trap_s;
  assign misalign_s    = 1'b0;
  assign tgt_s         = raw_dst_s;
  assign unused_trap_s = ^TRAP_PC;
`endif

  // Next-state and next-output computation for the fetch sequencer
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_d       = pend_q;
    pend_dst_d   = pend_dst_q;
    wait_cnt_d   = wait_cnt_q;
    if_valid_d   = if_valid_q;
    imem_err_d   = imem_err_q;
    flush_ifid_d = 1'b0;
    flush_idex_d = 1'b0;
    align_err_d  = 1'b0;
    case (state_q)
      ST_BOOT: begin
        // Redirects are not accepted before the first request is issued
        state_d    = ST_REQ;
        if_valid_d = 1'b0;
      end
      ST_REQ: begin
        flush_ifid_d = redir_s;
        flush_idex_d = ex_branchPermit;
        align_err_d  = misalign_s;
        if (imem_ack) begin
          wait_cnt_d = {WCW{1'b0}};
          if (redir_s) begin
            pc_d       = tgt_s;
            pend_d     = 1'b0;
            if_valid_d = 1'b0;
          end else if (pend_q) begin
            // Redirect arrived while waiting: drop this fetch, go to target
            pc_d       = pend_dst_q;
            pend_d     = 1'b0;
            if_valid_d = 1'b0;
          end else if (stall) begin
            if_valid_d = 1'b1;
            state_d    = ST_HOLD;
          end else begin
            if_valid_d = 1'b1;
            pc_d       = pc_inc_s;
          end
        end else begin
          if_valid_d = 1'b0;
          if (wait_cnt_q == WCW'(WAIT_LIMIT)) begin
            imem_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WCW'(1);
          end
          if (redir_s) begin
            // Newest redirect overwrites any earlier pending one
            pend_d     = 1'b1;
            pend_dst_d = tgt_s;
          end else begin
            pend_d     = pend_q;
          end
        end
      end
      ST_HOLD: begin
        flush_ifid_d = redir_s;
        flush_idex_d = ex_branchPermit;
        align_err_d  = misalign_s;
        if (redir_s) begin
          pc_d       = tgt_s;
          if_valid_d = 1'b0;
          state_d    = ST_REQ;
        end else if (!stall) begin
          pc_d       = pc_inc_s;
          if_valid_d = 1'b0;
          state_d    = ST_REQ;
        end else begin
          if_valid_d = 1'b1;
        end
      end
      default: begin
        state_d    = ST_BOOT;
        if_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      pend_q       <= 1'b0;
      pend_dst_q   <= 32'h0000_0000;
      wait_cnt_q   <= {WCW{1'b0}};
      if_valid_q   <= 1'b0;
      flush_ifid_q <= 1'b0;
      flush_idex_q <= 1'b0;
      imem_err_q   <= 1'b0;
      align_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      pend_dst_q   <= pend_dst_d;
      wait_cnt_q   <= wait_cnt_d;
      if_valid_q   <= if_valid_d;
      flush_ifid_q <= flush_ifid_d;
      flush_idex_q <= flush_idex_d;
      imem_err_q   <= imem_err_d;
      align_err_q  <= align_err_d;
    end
  end

  assign imem_req   = (state_q == ST_REQ);
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign if_valid   = if_valid_q;
  assign flush_ifid = flush_ifid_q;
  assign flush_idex = flush_idex_q;
  assign imem_err   = imem_err_q;
  assign align_err  = align_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios plus randomized traffic,
// checked by a scoreboard against a transaction-level fetch model.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] TRAP_PC    = 32'h0000_0180;
  localparam int          WAIT_LIMIT = 15;

  logic        clk = 1'b0;
  logic        rst_n, stall, id_p, ex_p, imem_ack;
  logic [31:0] id_dst, ex_dst;
  logic        imem_req, if_valid, flush_ifid, flush_idex, imem_err, align_err;
  logic [31:0] imem_addr, pc;

  pc_sequencer #(.RESET_PC(RESET_PC), .TRAP_PC(TRAP_PC), .WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .id_branchPermit(id_p), .id_branchDst(id_dst),
    .ex_branchPermit(ex_p), .ex_branchDst(ex_dst),
    .imem_ack(imem_ack), .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc),
    .if_valid(if_valid), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .imem_err(imem_err), .align_err(align_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        valid, fi, fx, err, ae, req;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: a fetch is either outstanding or being held; redirects
  // seen while a fetch is outstanding are remembered until it returns.
  bit          m_booted, m_holding, m_err;
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];
  int          m_waited;

  task automatic step(input bit r, input bit st, input bit ip, input logic [31:0] idd,
                      input bit ep, input logic [31:0] exd, input bit ak);
    exp_t        e;
    bit          redir;
    logic [31:0] tgt;
    rst_n = r; stall = st; id_p = ip; id_dst = idd; ex_p = ep; ex_dst = exd; imem_ack = ak;
    e.valid = 1'b0; e.fi = 1'b0; e.fx = 1'b0; e.ae = 1'b0;
    if (!r) begin
      m_booted = 1'b0; m_holding = 1'b0; m_err = 1'b0; m_pc = RESET_PC;
      m_pend.delete(); m_waited = 0;
    end else if (!m_booted) begin
      m_booted = 1'b1;
    end else begin
      redir = ep || ip;
      tgt   = ep ? exd : idd;
`ifdef PC_ALIGN_CHECK_EN
      if (redir && tgt[1:0] != 2'b00) begin
        tgt  = TRAP_PC;
        e.ae = 1'b1;
      end
`endif
      e.fi = redir;
      e.fx = ep;
      if (m_holding) begin
        if (redir) begin
          m_pc = tgt; m_holding = 1'b0;
        end else if (!st) begin
          m_pc = m_pc + 32'd4; m_holding = 1'b0;
        end else begin
          e.valid = 1'b1;
        end
      end else if (ak) begin
        m_waited = 0;
        if (redir) begin
          m_pc = tgt; m_pend.delete();
        end else if (m_pend.size() != 0) begin
          m_pc = m_pend.pop_front();
        end else begin
          e.valid = 1'b1;
          if (st) m_holding = 1'b1;
          else    m_pc = m_pc + 32'd4;
        end
      end else begin
        m_waited++;
        if (m_waited > WAIT_LIMIT) m_err = 1'b1;
        if (redir) begin
          m_pend.delete();
          m_pend.push_back(tgt);
        end
      end
    end
    e.pc  = m_pc;
    e.err = m_err;
    e.req = m_booted && !m_holding;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit ak);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, ak);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (vector %0d)", name, act, req, vectors);
    end
  endtask

  // Monitor: compares each registered output set against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        vectors++;
        chk("pc",         pc,                 e.pc);
        chk("imem_addr",  imem_addr,          e.pc);
        chk("if_valid",   {31'd0, if_valid},  {31'd0, e.valid});
        chk("flush_ifid", {31'd0, flush_ifid},{31'd0, e.fi});
        chk("flush_idex", {31'd0, flush_idex},{31'd0, e.fx});
        chk("imem_err",   {31'd0, imem_err},  {31'd0, e.err});
        chk("align_err",  {31'd0, align_err}, {31'd0, e.ae});
        chk("imem_req",   {31'd0, imem_req},  {31'd0, e.req});
      end
    end
  end

  initial begin
    logic [31:0] a, b;
    // Reset; a redirect during boot must be ignored
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h500, 1'b1);
    // Sequential fetch 0,4,8 then EX+ID redirect at pc=8
    idle(1'b1); idle(1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 32'h100, 1'b1);
    idle(1'b1); idle(1'b1);
    // Ack withheld three cycles, ID redirect in the first
    step(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
    idle(1'b0); idle(1'b0); idle(1'b1); idle(1'b1);
    // Stall over an ack at pc=0x10, then release
    step(1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    idle(1'b0); idle(1'b1);
    // Redirect while holding, with stall still asserted
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0);
    // Wait limit: 16 cycles without ack sets a sticky error
    for (int i = 0; i < 17; i++) idle(1'b0);
    idle(1'b1); idle(1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    idle(1'b0); idle(1'b1);
    // PC wrap-around
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    idle(1'b1); idle(1'b1);
    // Misaligned redirect target
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h102, 1'b1);
    idle(1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h203, 1'b0);
    idle(1'b1); idle(1'b1);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      a = $urandom();
      b = $urandom();
      if ($urandom_range(7) != 0) a[1:0] = 2'b00;
      if ($urandom_range(7) != 0) b[1:0] = 2'b00;
      step($urandom_range(99) != 0, $urandom_range(9) < 3,
           $urandom_range(9) == 0, a, $urandom_range(9) == 0, b,
           $urandom_range(9) < 7);
    end
    #5;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
